// File: rtl/code_decoder_3to8_buf_pkg.sv
`default_nettype none
// ============================================================================
// Package     : code_dec_pkg
// Description : Shared types, widths and helpers for the 3-to-8 decode buffer.
//               DEC_ACTIVE_LOW_EN selects active-low decoded lines.
// Revision    : 1.0 - initial release
// ============================================================================
package code_dec_pkg;

    localparam int CODE_W = 3;
    localparam int LINE_W = 8;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [LINE_W-1:0] line_t;

`ifdef DEC_ACTIVE_LOW_EN
    localparam line_t LINE_IDLE = 8'hFF;
`else
    localparam line_t LINE_IDLE = 8'h00;
`endif

    function automatic line_t to_onehot(input code_t c);
        return line_t'(1) << c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/code_decoder_3to8_buf_if.sv
`default_nettype none
// ============================================================================
// Interface   : code_decoder_3to8_buf_if
// Description : Code-in and decoded-line-out valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
interface code_decoder_3to8_buf_if;
    import code_dec_pkg::*;

    logic  in_valid;
    code_t in_code;
    logic  in_ready;
    logic  out_valid;
    line_t out_onehot;
    logic  out_ready;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_onehot
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_onehot
    );
endinterface
`default_nettype wire

// File: rtl/code_decoder_3to8_buf_fifo.sv
`default_nettype none
// ============================================================================
// Module      : code_fifo
// Description : DEPTH x W FIFO with occupancy level and look-ahead head data.
// Revision    : 1.0 - initial release
// ============================================================================
module code_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push_i,
    input  wire logic             pop_i,
    input  wire logic [W-1:0]     wdata_i,
    output logic      [W-1:0]     rdata_next_o,
    output logic      [LVL_W-1:0] level_o,
    output logic      [LVL_W-1:0] level_next_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // The head after this edge may be the entry being written right now.
    assign rdata_next_o = (push_i && (rd_ptr_d == wr_ptr_q)) ? wdata_i : mem_q[rd_ptr_d];
    assign level_o      = level_q;
    assign level_next_o = level_d;
    assign full_o       = (level_q == LVL_W'(DEPTH));
    assign empty_o      = (level_q == '0);

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/code_decoder_3to8_buf.sv
`default_nettype none
// ============================================================================
// Module      : code_decoder_3to8_buf
// Description : Buffered 3-to-8 decoder with sticky line flags and overflow.
//               DEC_ACTIVE_LOW_EN inverts out_onehot (idle 8'hFF).
// Revision    : 1.0 - initial release
// ============================================================================
module code_decoder_3to8_buf
    import code_dec_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    code_decoder_3to8_buf_if.slave  bus,
    output logic      [LVL_W-1:0]   level,
    output line_t                   sticky,
    input  wire line_t              sticky_clr,
    output logic                    overflow,
    input  wire logic               ovf_clr
);
    logic             push_w;
    logic             pop_w;
    logic             full_w;
    logic             empty_w;
    code_t            head_next_w;
    logic [LVL_W-1:0] level_next_w;

    line_t onehot_q, onehot_d;
    line_t sticky_q, sticky_d;
    logic  ovf_q, ovf_d;

    assign push_w = bus.in_valid && !full_w;
    assign pop_w  = !empty_w && bus.out_ready;

    code_fifo #(
        .DEPTH (DEPTH),
        .W     (CODE_W),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push_w),
        .pop_i        (pop_w),
        .wdata_i      (bus.in_code),
        .rdata_next_o (head_next_w),
        .level_o      (level),
        .level_next_o (level_next_w),
        .full_o       (full_w),
        .empty_o      (empty_w)
    );

    // XOR with the idle pattern yields the selected output polarity.
    always_comb begin
        onehot_d = (level_next_w != '0) ? (to_onehot(head_next_w) ^ LINE_IDLE) : LINE_IDLE;
        sticky_d = (sticky_q & ~sticky_clr) | (push_w ? to_onehot(bus.in_code) : '0);
        ovf_d    = (ovf_q & ~ovf_clr) | (bus.in_valid & full_w);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot_q <= LINE_IDLE;
            sticky_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            onehot_q <= onehot_d;
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.in_ready   = !full_w;
    assign bus.out_valid  = !empty_w;
    assign bus.out_onehot = onehot_q;
    assign sticky         = sticky_q;
    assign overflow       = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_code_decoder_3to8_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_decoder_3to8_buf
// Description : Directed self-checking bench for code_decoder_3to8_buf.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_decoder_3to8_buf;
    import code_dec_pkg::*;

    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

`ifdef DEC_ACTIVE_LOW_EN
    localparam logic [7:0] POL = 8'hFF;
`else
    localparam logic [7:0] POL = 8'h00;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [LVL_W-1:0] level;
    line_t            sticky;
    line_t            sticky_clr;
    logic             overflow;
    logic             ovf_clr;

    int tests = 0;
    int fails = 0;

    code_decoder_3to8_buf_if bus_if ();

    code_decoder_3to8_buf #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if),
        .level      (level),
        .sticky     (sticky),
        .sticky_clr (sticky_clr),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".out_valid"}, 32'(bus_if.out_valid), 32'h0);
        check({tag, ".out_onehot"}, 32'(bus_if.out_onehot), 32'(POL));
        check({tag, ".in_ready"}, 32'(bus_if.in_ready), 32'h1);
        check({tag, ".level"}, 32'(level), 32'h0);
        check({tag, ".sticky"}, 32'(sticky), 32'h0);
        check({tag, ".overflow"}, 32'(overflow), 32'h0);
    endtask

    initial begin
        rst_n             = 1'b0;
        bus_if.in_valid   = 1'b0;
        bus_if.in_code    = 3'd0;
        bus_if.out_ready  = 1'b0;
        sticky_clr        = 8'h00;
        ovf_clr           = 1'b0;
        #12;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single push of code 5, then pop
        bus_if.in_valid = 1'b1; bus_if.in_code = 3'd5;
        tick();
        bus_if.in_valid = 1'b0;
        check("push5.out_valid", 32'(bus_if.out_valid), 32'h1);
        check("push5.out_onehot", 32'(bus_if.out_onehot), 32'(8'h20 ^ POL));
        check("push5.level", 32'(level), 32'h1);
        check("push5.sticky", 32'(sticky), 32'h20);
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
        check("pop5.out_valid", 32'(bus_if.out_valid), 32'h0);
        check("pop5.out_onehot", 32'(bus_if.out_onehot), 32'(POL));

        // Fill, overflow, drain
        for (int i = 0; i < 4; i++) begin
            bus_if.in_valid = 1'b1; bus_if.in_code = 3'(i);
            tick();
        end
        bus_if.in_valid = 1'b0;
        check("fill.level", 32'(level), 32'h4);
        check("fill.in_ready", 32'(bus_if.in_ready), 32'h0);
        bus_if.in_valid = 1'b1; bus_if.in_code = 3'd7;
        tick();
        bus_if.in_valid = 1'b0;
        check("ovf.overflow", 32'(overflow), 32'h1);
        check("ovf.sticky", 32'(sticky), 32'h2F);
        check("ovf.level", 32'(level), 32'h4);
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d.out_onehot", i), 32'(bus_if.out_onehot),
                  32'((8'h01 << i) ^ POL));
            tick();
        end
        bus_if.out_ready = 1'b0;
        check("drain.out_valid", 32'(bus_if.out_valid), 32'h0);
        check("drain.out_onehot", 32'(bus_if.out_onehot), 32'(POL));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovfclr.overflow", 32'(overflow), 32'h0);

        // Simultaneous push/pop at level 2, pointers wrap twice
        bus_if.in_valid = 1'b1; bus_if.in_code = 3'd3;
        tick();
        bus_if.in_code = 3'd4;
        tick();
        check("pp.pre_level", 32'(level), 32'h2);
        check("pp.pre_head", 32'(bus_if.out_onehot), 32'(8'h08 ^ POL));
        bus_if.in_code   = 3'd6;
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("pp%0d.level", i), 32'(level), 32'h2);
            check($sformatf("pp%0d.out_onehot", i), 32'(bus_if.out_onehot),
                  32'(((i == 0) ? 8'h10 : 8'h40) ^ POL));
        end
        bus_if.in_valid = 1'b0;
        tick();
        tick();
        bus_if.out_ready = 1'b0;
        check("pp.empty", 32'(bus_if.out_valid), 32'h0);
        check("pp.sticky", 32'(sticky), 32'h7F);

        // Sticky set beats same-cycle clear, then clear alone
        bus_if.in_valid = 1'b1; bus_if.in_code = 3'd6; sticky_clr = 8'h40;
        tick();
        bus_if.in_valid = 1'b0;
        check("stk.setwins", 32'(sticky[6]), 32'h1);
        tick();
        sticky_clr = 8'h00;
        check("stk.clear", 32'(sticky[6]), 32'h0);
        check("stk.others", 32'(sticky), 32'h3F);

        // Asynchronous reset mid-cycle with level 3
        bus_if.in_valid = 1'b1; bus_if.in_code = 3'd1;
        tick();
        tick();
        bus_if.in_valid = 1'b0;
        check("pre_rst.level", 32'(level), 32'h3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.in_valid = 1'b1; bus_if.in_code = 3'd2;
        tick();
        check("post_rst.out_onehot", 32'(bus_if.out_onehot), 32'(8'h04 ^ POL));
        check("post_rst.level", 32'(level), 32'h1);

        // Full with same-cycle pop: no push, offered code dropped
        bus_if.in_code = 3'd1; tick();
        bus_if.in_code = 3'd3; tick();
        bus_if.in_code = 3'd5; tick();
        check("full2.level", 32'(level), 32'h4);
        bus_if.in_code   = 3'd7;
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        check("full_pop.level", 32'(level), 32'h3);
        check("full_pop.overflow", 32'(overflow), 32'h1);
        check("full_pop.out_onehot", 32'(bus_if.out_onehot), 32'(8'h02 ^ POL));
        check("full_pop.sticky", 32'(sticky), 32'h2E);

        // Overflow set beats same-cycle clear
        bus_if.in_valid = 1'b1; bus_if.in_code = 3'd0; tick();
        bus_if.in_code = 3'd4; ovf_clr = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        check("ovf.setwins", 32'(overflow), 32'h1);
        tick();
        ovf_clr = 1'b0;
        check("ovf.cleared", 32'(overflow), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
